// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the sequential multiplier: state encoding,
// the ALU control code for MUL, and default datapath sizing.
package mul_seq_ctrl_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 5;

    // ALU control code that triggers the multi-cycle multiply.
    localparam logic [4:0] ALU_MUL = 5'b01000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/mul_seq_dp.sv
// Radix-2 shift-add multiply datapath: holds acc/mcand/mplier/cnt.
// Ports: clk_i, rst_i (async, active-low), clear_i, load_i, step_i,
//   src1_i, src2_i, acc_o, acc_next_o, cnt_last_o, and mplier_zero_o
//   when MUL_SEQ_EARLY_TERM_EN is defined.
module mul_seq_dp
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
`ifdef MUL_SEQ_EARLY_TERM_EN
    output logic             mplier_zero_o,
`endif
    output logic [WIDTH-1:0] acc_o,
    output logic [WIDTH-1:0] acc_next_o,
    output logic             cnt_last_o
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    // Sum wraps modulo 2**WIDTH; only the low product bits are kept.
    assign acc_next_o = mplier[0] ? acc + mcand : acc;
    assign acc_o      = acc;
    assign cnt_last_o = (cnt == CNT_W'(WIDTH - 1));

`ifdef MUL_SEQ_EARLY_TERM_EN
    assign mplier_zero_o = (mplier == '0);
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (clear_i) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (load_i) begin
            acc    <= '0;
            mcand  <= src1_i;
            mplier <= src2_i;
            cnt    <= '0;
        end else if (step_i) begin
            acc    <= acc_next_o;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Multi-cycle MUL sequencer: FSM, CPU stall and done pulse around mul_seq_dp.
// Ports: clk_i, rst_i (async, active-low), start_i, flush_i, src1_i, src2_i,
//   result_o, busy_o, stall_o, done_o.
// Build option: MUL_SEQ_EARLY_TERM_EN ends RUN once the multiplier is zero.
module mul_seq_ctrl
    import mul_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    output logic [WIDTH-1:0] result_o,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o
);

    state_t           state;
    logic             accept;
    logic             early_stop;
    logic             dp_load;
    logic             dp_step;
    logic             dp_clear;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             cnt_last;

`ifdef MUL_SEQ_EARLY_TERM_EN
    logic mplier_zero;
    assign early_stop = mplier_zero;
`else
    assign early_stop = 1'b0;
`endif

    assign accept   = (state == IDLE) && start_i && !flush_i;
    assign dp_load  = accept;
    assign dp_clear = (state == RUN) && flush_i;
    assign dp_step  = (state == RUN) && !flush_i && !early_stop;

    // DONE drops the stall so the CPU advances with the result.
    assign stall_o = accept || (state == RUN);

    mul_seq_dp #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_dp (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .clear_i       (dp_clear),
        .load_i        (dp_load),
        .step_i        (dp_step),
        .src1_i        (src1_i),
        .src2_i        (src2_i),
`ifdef MUL_SEQ_EARLY_TERM_EN
        .mplier_zero_o (mplier_zero),
`endif
        .acc_o         (acc),
        .acc_next_o    (acc_next),
        .cnt_last_o    (cnt_last)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            result_o <= '0;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (accept) begin
                        state  <= RUN;
                        busy_o <= 1'b1;
                    end
                end
                RUN: begin
                    if (flush_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (early_stop) begin
                        state    <= DONE;
                        result_o <= acc;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                    end else if (cnt_last) begin
                        // Commit includes the add of this last iteration.
                        state    <= DONE;
                        result_o <= acc_next;
                        busy_o   <= 1'b0;
                        done_o   <= 1'b1;
                    end
                end
                DONE: begin
                    // A start_i still high here belongs to this instruction.
                    state  <= IDLE;
                    done_o <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed self-checking bench for mul_seq_ctrl.
// Latency counts edges from the start-sampling edge (that edge counts as 1).
module tb_mul_seq_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] result;
    logic        busy;
    logic        stall;
    logic        done;

    int n_cmp;
    int n_bad;

    mul_seq_ctrl dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .flush_i  (flush),
        .src1_i   (src1),
        .src2_i   (src2),
        .result_o (result),
        .busy_o   (busy),
        .stall_o  (stall),
        .done_o   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one request and measures it; callers do the comparisons.
    task automatic mul_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] res,
                          output int bad, output int extra);
        bad   = 0;
        extra = 0;
        lat   = 0;
        src1  = a;
        src2  = b;
        flush = 1'b0;
        start = 1'b1;
        #1;
        if (stall !== 1'b1) bad++;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (done === 1'b1) begin
                lat = n;
                break;
            end
            if (stall !== 1'b1 || busy !== 1'b1) bad++;
        end
        if (lat != 0 && (stall !== 1'b0 || busy !== 1'b0)) bad++;
        res   = result;
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done !== 1'b0) extra++;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        src1  = 32'd0;
        src2  = 32'd0;
        tick();
        n_cmp++;
        if ({result, busy, stall, done} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {result, busy, stall, done});
        end
        #3 rst = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release busy=%b done=%b exp=0/0", busy, done);
        end
    endtask

    task automatic test_basic();
        int lat, bad, extra;
        logic [31:0] res;
        mul_op(32'd3, 32'd5, lat, res, bad, extra);
        n_cmp++;
        if (lat != 33) begin
            n_bad++;
            $display("FAIL basic_latency got=%0d exp=33", lat);
        end
        n_cmp++;
        if (res !== 32'd15) begin
            n_bad++;
            $display("FAIL basic_result got=%0d exp=15", res);
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL basic_stall_busy got=%0d bad samples exp=0", bad);
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL basic_done_width got=%0d extra exp=0", extra);
        end
        n_cmp++;
        if (result !== 32'd15) begin
            n_bad++;
            $display("FAIL basic_hold got=%0d exp=15", result);
        end
    endtask

    task automatic test_overflow();
        int lat, bad, extra;
        logic [31:0] res;
        mul_op(32'hFFFF_FFFE, 32'd3, lat, res, bad, extra);
        n_cmp++;
        if (res !== 32'hFFFF_FFFA || lat != 33) begin
            n_bad++;
            $display("FAIL neg2x3 got=%h lat=%0d exp=fffffffa lat=33", res, lat);
        end
        mul_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, bad, extra);
        n_cmp++;
        if (res !== 32'h0000_0001 || lat != 33) begin
            n_bad++;
            $display("FAIL neg1xneg1 got=%h lat=%0d exp=00000001 lat=33",
                     res, lat);
        end
        mul_op(32'h0001_0000, 32'h0001_0003, lat, res, bad, extra);
        n_cmp++;
        if (res !== 32'h0003_0000) begin
            n_bad++;
            $display("FAIL wrap_high got=%h exp=00030000", res);
        end
    endtask

    task automatic test_back_to_back();
        int ndone, first, second;
        ndone  = 0;
        first  = 0;
        second = 0;
        src1   = 32'd2;
        src2   = 32'd3;
        flush  = 1'b0;
        start  = 1'b1;
        for (int n = 1; n <= 70; n++) begin
            tick();
            if (done === 1'b1) begin
                ndone++;
                if (first == 0) first = n;
                else if (second == 0) second = n;
            end
            if (n == 8) start = 1'b0;
            if (n == 9) start = 1'b1;
            if (n == 12) begin
                src1 = 32'd100;
                src2 = 32'd100;
            end
            if (n == 33) begin
                n_cmp++;
                if (result !== 32'd6) begin
                    n_bad++;
                    $display("FAIL b2b_first_result got=%0d exp=6", result);
                end
            end
            if (n == 34) begin
                src1 = 32'd4;
                src2 = 32'd5;
            end
        end
        start = 1'b0;
        n_cmp++;
        if (first != 33 || second != 67 || ndone != 2) begin
            n_bad++;
            $display("FAIL b2b_done_times got=%0d,%0d n=%0d exp=33,67 n=2",
                     first, second, ndone);
        end
        n_cmp++;
        if (result !== 32'd20) begin
            n_bad++;
            $display("FAIL b2b_second_result got=%0d exp=20", result);
        end
        for (int k = 0; k < 40; k++) tick();
    endtask

    task automatic test_flush();
        int lat, bad, extra, ndone;
        logic [31:0] res;
        logic [31:0] prior;
        prior = result;
        ndone = 0;
        src1  = 32'd7;
        src2  = 32'd9;
        start = 1'b1;
        flush = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        flush = 1'b1;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || stall !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_to_idle busy=%b stall=%b exp=0/0", busy, stall);
        end
        for (int n = 0; n < 4; n++) begin
            tick();
            if (busy !== 1'b0) ndone++;
        end
        flush = 1'b0;
        start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        n_cmp++;
        if (ndone != 0) begin
            n_bad++;
            $display("FAIL flush_no_done got=%0d events exp=0", ndone);
        end
        n_cmp++;
        if (result !== prior) begin
            n_bad++;
            $display("FAIL flush_result_kept got=%0d exp=%0d", result, prior);
        end
        mul_op(32'd7, 32'd9, lat, res, bad, extra);
        n_cmp++;
        if (res !== 32'd63 || lat != 33) begin
            n_bad++;
            $display("FAIL after_flush got=%0d lat=%0d exp=63 lat=33", res, lat);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bad, extra;
        logic [31:0] res;
        src1  = 32'd5;
        src2  = 32'd5;
        start = 1'b1;
        for (int n = 1; n <= 4; n++) tick();
        start = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({result, busy, stall, done} !== 35'd0) begin
            n_bad++;
            $display("FAIL reset_mid_run got=%h exp=0",
                     {result, busy, stall, done});
        end
        tick();
        #2 rst = 1'b1;
        tick();
        mul_op(32'd10, 32'd11, lat, res, bad, extra);
        n_cmp++;
        if (res !== 32'd110 || lat != 33 || bad != 0) begin
            n_bad++;
            $display("FAIL post_reset got=%0d lat=%0d bad=%0d exp=110 lat=33",
                     res, lat, bad);
        end
    endtask

    task automatic test_early_term();
        int lat, bad, extra;
        int e0, e4, e1;
        logic [31:0] res;
`ifdef MUL_SEQ_EARLY_TERM_EN
        e0 = 2;
        e4 = 5;
        e1 = 3;
`else
        e0 = 33;
        e4 = 33;
        e1 = 33;
`endif
        mul_op(32'd5, 32'd0, lat, res, bad, extra);
        n_cmp++;
        if (res !== 32'd0 || lat != e0) begin
            n_bad++;
            $display("FAIL src2_zero got=%0d lat=%0d exp=0 lat=%0d", res, lat, e0);
        end
        mul_op(32'd6, 32'd4, lat, res, bad, extra);
        n_cmp++;
        if (res !== 32'd24 || lat != e4) begin
            n_bad++;
            $display("FAIL src2_four got=%0d lat=%0d exp=24 lat=%0d",
                     res, lat, e4);
        end
        mul_op(32'd9, 32'd1, lat, res, bad, extra);
        n_cmp++;
        if (res !== 32'd9 || lat != e1) begin
            n_bad++;
            $display("FAIL src2_one got=%0d lat=%0d exp=9 lat=%0d", res, lat, e1);
        end
        mul_op(32'd3, 32'h8000_0000, lat, res, bad, extra);
        n_cmp++;
        if (res !== 32'h8000_0000 || lat != 33) begin
            n_bad++;
            $display("FAIL src2_msb got=%h lat=%0d exp=80000000 lat=33",
                     res, lat);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_flush();
        test_reset_mid_run();
        test_early_term();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
